// File: rtl/regadder_arbiter_if.sv
// Requester handshake and register-file bus shared by the arbiter and its environment.
// The arbiter connects through the slave modport; requesters plus the register file
// and adder connect through the master modport.
interface regadder_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5
);
  // Requester 0
  logic                     req0Valid;
  logic [REG_NUM_WIDTH-1:0] req0SrcA;
  logic [REG_NUM_WIDTH-1:0] req0SrcB;
  logic [REG_NUM_WIDTH-1:0] req0Dst;
  logic                     req0Ready;
  logic                     req0Done;

  // Requester 1
  logic                     req1Valid;
  logic [REG_NUM_WIDTH-1:0] req1SrcA;
  logic [REG_NUM_WIDTH-1:0] req1SrcB;
  logic [REG_NUM_WIDTH-1:0] req1Dst;
  logic                     req1Ready;
  logic                     req1Done;

  // Write-back value reported to requesters
  logic [DATA_WIDTH-1:0]    result;

  // Register file read ports and adder output
  logic [REG_NUM_WIDTH-1:0] rdNumA;
  logic [REG_NUM_WIDTH-1:0] rdNumB;
  logic [DATA_WIDTH-1:0]    sumIn;

  // Register file write port
  logic [DATA_WIDTH-1:0]    wrData;
  logic [REG_NUM_WIDTH-1:0] wrNum;
  logic                     wrEnable;

  modport slave (
    input  req0Valid, req0SrcA, req0SrcB, req0Dst,
    input  req1Valid, req1SrcA, req1SrcB, req1Dst,
    input  sumIn,
    output req0Ready, req0Done, req1Ready, req1Done,
    output result, rdNumA, rdNumB, wrData, wrNum, wrEnable
  );

  modport master (
    output req0Valid, req0SrcA, req0SrcB, req0Dst,
    output req1Valid, req1SrcA, req1SrcB, req1Dst,
    output sumIn,
    input  req0Ready, req0Done, req1Ready, req1Done,
    input  result, rdNumA, rdNumB, wrData, wrNum, wrEnable
  );
endinterface

// File: rtl/regadder_arbiter.sv
// Two-requester round-robin arbiter and write-back sequencer for the register-file
// plus adder datapath. One op issues per cycle; its sum is held in a one-entry
// write-back register and written to the register file on the following cycle.
// A candidate whose sources match the pending write-back destination is stalled
// for one cycle so requesters never observe a read-after-write hazard.
module regadder_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5
) (
  input logic               clk,
  input logic               rst,
  regadder_arbiter_if.slave bus
);

  // Write-back register and round-robin pointer
  logic                     r_wb_valid;
  logic [REG_NUM_WIDTH-1:0] r_wb_num;
  logic [DATA_WIDTH-1:0]    r_wb_data;
  logic                     r_wb_owner;
  logic                     r_last_grant;

  // Candidate selection and issue decision
  logic                     w_cand_valid;
  logic                     w_cand;
  logic [REG_NUM_WIDTH-1:0] w_src_a;
  logic [REG_NUM_WIDTH-1:0] w_src_b;
  logic [REG_NUM_WIDTH-1:0] w_dst;
  logic                     w_hazard;
  logic                     w_issue;

  // Pick the candidate: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    w_cand_valid = bus.req0Valid | bus.req1Valid;
    w_cand       = 1'b0;
    if (bus.req0Valid && bus.req1Valid) begin
      w_cand = ~r_last_grant;
    end else if (bus.req1Valid) begin
      w_cand = 1'b1;
    end
  end

  // Route the candidate's operand and destination register numbers.
  always_comb begin
    w_src_a = bus.req0SrcA;
    w_src_b = bus.req0SrcB;
    w_dst   = bus.req0Dst;
    if (w_cand) begin
      w_src_a = bus.req1SrcA;
      w_src_b = bus.req1SrcB;
      w_dst   = bus.req1Dst;
    end
  end

  // A source matching the pending write would read a stale value, so hold the
  // candidate until the write has landed. The issue is also blocked while reset
  // is asserted so that every output reads zero during reset.
  assign w_hazard = r_wb_valid && ((w_src_a == r_wb_num) || (w_src_b == r_wb_num));
  assign w_issue  = rst && w_cand_valid && !w_hazard;

  // Issue-side outputs: only the granted requester sees Ready; idle read ports park at 0.
  assign bus.req0Ready = w_issue && (w_cand == 1'b0);
  assign bus.req1Ready = w_issue && (w_cand == 1'b1);
  assign bus.rdNumA    = w_issue ? w_src_a : '0;
  assign bus.rdNumB    = w_issue ? w_src_b : '0;

  // Write-back outputs come straight from the write-back register.
  assign bus.wrEnable  = r_wb_valid;
  assign bus.wrNum     = r_wb_num;
  assign bus.wrData    = r_wb_data;
  assign bus.result    = r_wb_data;
  assign bus.req0Done  = r_wb_valid && (r_wb_owner == 1'b0);
  assign bus.req1Done  = r_wb_valid && (r_wb_owner == 1'b1);

  // Capture the issued op's sum for write-back next cycle; otherwise retire the entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid   <= 1'b0;
      r_wb_num     <= '0;
      r_wb_data    <= '0;
      r_wb_owner   <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_issue) begin
      r_wb_valid   <= 1'b1;
      r_wb_num     <= w_dst;
      r_wb_data    <= bus.sumIn;
      r_wb_owner   <= w_cand;
      r_last_grant <= w_cand;
    end else begin
      r_wb_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regadder_arbiter.sv
// Directed testbench for regadder_arbiter: a behavioural register file and adder
// surround the arbiter, and each task drives one scenario with hand-computed expectations.
module tb_regadder_arbiter;

  localparam int DW = 32;
  localparam int RW = 5;

  logic clk;
  logic rst;

  regadder_arbiter_if #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RW)) bus ();

  regadder_arbiter #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: arbiter writes take priority over bench preloads.
  logic [DW-1:0] regs [32];
  logic          pl_en;
  logic [RW-1:0] pl_num;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (bus.wrEnable) regs[bus.wrNum] <= bus.wrData;
    else if (pl_en)   regs[pl_num]    <= pl_data;
  end

  assign bus.sumIn = regs[bus.rdNumA] + regs[bus.rdNumB];

  int n_tests;
  int n_fail;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.req0Valid = 1'b0; bus.req0SrcA = '0; bus.req0SrcB = '0; bus.req0Dst = '0;
    bus.req1Valid = 1'b0; bus.req1SrcA = '0; bus.req1SrcB = '0; bus.req1Dst = '0;
  endtask

  task automatic preload(input logic [RW-1:0] n, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_num = n; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_reqs();
    bus.req0Valid = 1'b1;
    rst = 1'b0;
    tick(); tick();
    n_tests++; if (bus.wrEnable !== 1'b0) begin n_fail++; $display("FAIL reset_wrEnable got=%b exp=0", bus.wrEnable); end
    n_tests++; if (bus.req0Ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0Ready got=%b exp=0", bus.req0Ready); end
    n_tests++; if ({bus.req1Ready, bus.req0Done, bus.req1Done} !== 3'b000) begin n_fail++; $display("FAIL reset_rdy_done got=%b exp=000", {bus.req1Ready, bus.req0Done, bus.req1Done}); end
    n_tests++; if ({bus.rdNumA, bus.rdNumB, bus.wrNum} !== 15'd0) begin n_fail++; $display("FAIL reset_nums got=%h exp=0", {bus.rdNumA, bus.rdNumB, bus.wrNum}); end
    n_tests++; if ({bus.wrData, bus.result} !== 64'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", {bus.wrData, bus.result}); end
    bus.req0Valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    n_tests++; if (bus.wrEnable !== 1'b0) begin n_fail++; $display("FAIL idle_wrEnable got=%b exp=0", bus.wrEnable); end
    n_tests++; if ({bus.req0Ready, bus.req1Ready} !== 2'b00) begin n_fail++; $display("FAIL idle_ready got=%b exp=00", {bus.req0Ready, bus.req1Ready}); end
  endtask

  task automatic test_single_op();
    preload(5'd3, 32'd5);
    preload(5'd4, 32'd7);
    bus.req0Valid = 1'b1; bus.req0SrcA = 5'd3; bus.req0SrcB = 5'd4; bus.req0Dst = 5'd9;
    #1;
    n_tests++; if (bus.req0Ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", bus.req0Ready); end
    n_tests++; if ({bus.rdNumA, bus.rdNumB} !== {5'd3, 5'd4}) begin n_fail++; $display("FAIL single_rdnum got=%0d,%0d exp=3,4", bus.rdNumA, bus.rdNumB); end
    tick();
    bus.req0Valid = 1'b0;
    #1;
    n_tests++; if (bus.wrEnable !== 1'b1) begin n_fail++; $display("FAIL single_wrEnable got=%b exp=1", bus.wrEnable); end
    n_tests++; if (bus.wrNum !== 5'd9) begin n_fail++; $display("FAIL single_wrNum got=%0d exp=9", bus.wrNum); end
    n_tests++; if (bus.wrData !== 32'd12) begin n_fail++; $display("FAIL single_wrData got=%0d exp=12", bus.wrData); end
    n_tests++; if ({bus.req0Done, bus.req1Done} !== 2'b10) begin n_fail++; $display("FAIL single_done got=%b exp=10", {bus.req0Done, bus.req1Done}); end
    n_tests++; if (bus.result !== 32'd12) begin n_fail++; $display("FAIL single_result got=%0d exp=12", bus.result); end
    tick();
    n_tests++; if (regs[9] !== 32'd12) begin n_fail++; $display("FAIL single_R9 got=%0d exp=12", regs[9]); end
    n_tests++; if (bus.wrEnable !== 1'b0) begin n_fail++; $display("FAIL single_wr_after got=%b exp=0", bus.wrEnable); end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_sum [2];
    exp_sum[0] = 32'd3;
    exp_sum[1] = 32'd7;
    do_reset();
    preload(5'd10, 32'd1);
    preload(5'd11, 32'd2);
    preload(5'd12, 32'd3);
    preload(5'd13, 32'd4);
    bus.req0Valid = 1'b1; bus.req0SrcA = 5'd10; bus.req0SrcB = 5'd11; bus.req0Dst = 5'd20;
    bus.req1Valid = 1'b1; bus.req1SrcA = 5'd12; bus.req1SrcB = 5'd13; bus.req1Dst = 5'd21;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++;
      if ({bus.req0Ready, bus.req1Ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, {bus.req0Ready, bus.req1Ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (k > 0) begin
        n_tests++;
        if ({bus.req0Done, bus.req1Done} !== (((k - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL rr_done[%0d] got=%b exp=%b", k, {bus.req0Done, bus.req1Done}, ((k - 1) % 2 == 0) ? 2'b10 : 2'b01);
        end
        n_tests++;
        if (bus.wrData !== exp_sum[(k - 1) % 2]) begin
          n_fail++; $display("FAIL rr_wrData[%0d] got=%0d exp=%0d", k, bus.wrData, exp_sum[(k - 1) % 2]);
        end
      end
      tick();
    end
    idle_reqs();
    #1;
    n_tests++; if ({bus.req0Done, bus.req1Done} !== 2'b01) begin n_fail++; $display("FAIL rr_last_done got=%b exp=01", {bus.req0Done, bus.req1Done}); end
    n_tests++; if (bus.wrNum !== 5'd21) begin n_fail++; $display("FAIL rr_last_wrNum got=%0d exp=21", bus.wrNum); end
    tick();
  endtask

  task automatic test_raw_stall();
    preload(5'd1, 32'd10);
    preload(5'd2, 32'd20);
    preload(5'd6, 32'd4);
    bus.req0Valid = 1'b1; bus.req0SrcA = 5'd1; bus.req0SrcB = 5'd2; bus.req0Dst = 5'd5;
    #1;
    n_tests++; if (bus.req0Ready !== 1'b1) begin n_fail++; $display("FAIL raw_T_ready0 got=%b exp=1", bus.req0Ready); end
    tick();
    bus.req0Valid = 1'b0;
    bus.req1Valid = 1'b1; bus.req1SrcA = 5'd5; bus.req1SrcB = 5'd6; bus.req1Dst = 5'd7;
    #1;
    n_tests++; if (bus.req1Ready !== 1'b0) begin n_fail++; $display("FAIL raw_T1_stall got=%b exp=0", bus.req1Ready); end
    n_tests++; if ({bus.rdNumA, bus.rdNumB} !== 10'd0) begin n_fail++; $display("FAIL raw_T1_rdnum got=%0d,%0d exp=0,0", bus.rdNumA, bus.rdNumB); end
    n_tests++; if ({bus.wrEnable, bus.req0Done, bus.wrNum, bus.wrData} !== {1'b1, 1'b1, 5'd5, 32'd30}) begin
      n_fail++; $display("FAIL raw_T1_wb got=%b,%b,%0d,%0d exp=1,1,5,30", bus.wrEnable, bus.req0Done, bus.wrNum, bus.wrData);
    end
    tick();
    #1;
    n_tests++; if (bus.req1Ready !== 1'b1) begin n_fail++; $display("FAIL raw_T2_ready1 got=%b exp=1", bus.req1Ready); end
    n_tests++; if (bus.wrEnable !== 1'b0) begin n_fail++; $display("FAIL raw_T2_wrEnable got=%b exp=0", bus.wrEnable); end
    tick();
    idle_reqs();
    #1;
    n_tests++; if ({bus.req1Done, bus.req0Done} !== 2'b10) begin n_fail++; $display("FAIL raw_T3_done got=%b exp=10", {bus.req1Done, bus.req0Done}); end
    n_tests++; if ({bus.wrNum, bus.wrData} !== {5'd7, 32'd34}) begin n_fail++; $display("FAIL raw_T3_wb got=%0d,%0d exp=7,34", bus.wrNum, bus.wrData); end
    tick();
    n_tests++; if (regs[7] !== 32'd34) begin n_fail++; $display("FAIL raw_R7 got=%0d exp=34", regs[7]); end
  endtask

  task automatic test_back_to_back();
    preload(5'd0, 32'hFFFF_FFFF);
    preload(5'd1, 32'd2);
    bus.req1Valid = 1'b1; bus.req1SrcA = 5'd0; bus.req1SrcB = 5'd1; bus.req1Dst = 5'd2;
    #1;
    n_tests++; if (bus.req1Ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready1 got=%b exp=1", bus.req1Ready); end
    tick();
    bus.req1SrcA = 5'd1; bus.req1SrcB = 5'd1; bus.req1Dst = 5'd3;
    #1;
    n_tests++; if (bus.wrData !== 32'h0000_0001) begin n_fail++; $display("FAIL wrap_wrData got=%h exp=00000001", bus.wrData); end
    n_tests++; if ({bus.req1Done, bus.wrNum} !== {1'b1, 5'd2}) begin n_fail++; $display("FAIL wrap_done got=%b,%0d exp=1,2", bus.req1Done, bus.wrNum); end
    n_tests++; if (bus.req1Ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got=%b exp=1", bus.req1Ready); end
    tick();
    idle_reqs();
    #1;
    n_tests++; if ({bus.wrEnable, bus.wrNum, bus.wrData} !== {1'b1, 5'd3, 32'd4}) begin
      n_fail++; $display("FAIL double_wb got=%b,%0d,%0d exp=1,3,4", bus.wrEnable, bus.wrNum, bus.wrData);
    end
    tick();
    n_tests++; if (regs[2] !== 32'd1) begin n_fail++; $display("FAIL wrap_R2 got=%h exp=00000001", regs[2]); end
  endtask

  task automatic test_reset_mid_op();
    preload(5'd8, 32'h55);
    bus.req0Valid = 1'b1; bus.req0SrcA = 5'd3; bus.req0SrcB = 5'd4; bus.req0Dst = 5'd8;
    #1;
    n_tests++; if (bus.req0Ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready0 got=%b exp=1", bus.req0Ready); end
    tick();
    bus.req0Valid = 1'b0;
    #1;
    n_tests++; if (bus.wrEnable !== 1'b1) begin n_fail++; $display("FAIL mid_wr_before got=%b exp=1", bus.wrEnable); end
    rst = 1'b0;
    #1;
    n_tests++; if (bus.wrEnable !== 1'b0) begin n_fail++; $display("FAIL mid_wr_drop got=%b exp=0", bus.wrEnable); end
    n_tests++; if (bus.req0Done !== 1'b0) begin n_fail++; $display("FAIL mid_done got=%b exp=0", bus.req0Done); end
    tick(); tick();
    rst = 1'b1;
    tick();
    n_tests++; if (regs[8] !== 32'h55) begin n_fail++; $display("FAIL mid_R8 got=%h exp=55", regs[8]); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pl_en   = 1'b0;
    pl_num  = '0;
    pl_data = '0;
    rst     = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    idle_reqs();
    test_reset();
    test_single_op();
    test_round_robin();
    test_raw_stall();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regadder_arbiter.md
# regadder_arbiter

Two-requester round-robin arbiter and write-back sequencer for the register-file + adder datapath. Each requester issues "R[dst] ← R[srcA] + R[srcB]" operations. The arbiter owns both read ports and the write port. The adder sum is captured into a one-entry write-back register and written on the following cycle. Reads of a register with a pending write are stalled, so no read-after-write hazard is visible to requesters.

## Interface
Parameters:
- DATA_WIDTH, 32, width of register data / `DataPath`
- REG_NUM_WIDTH, 5, width of register number / `RegNumPath` (32 registers)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- req0Valid  input  1  requester 0 has an op
- req0SrcA, req0SrcB, req0Dst  input  REG_NUM_WIDTH each  requester 0 operand/destination registers
- req0Ready  output  1  op 0 accepted this cycle (transfer when req0Valid && req0Ready)
- req0Done  output  1  one-cycle pulse: op 0 written back this cycle
- req1Valid, req1SrcA, req1SrcB, req1Dst, req1Ready, req1Done  same as above, for requester 1
- result  output  DATA_WIDTH  value being written back; valid when reqNDone = 1
- rdNumA, rdNumB  output  REG_NUM_WIDTH  register-file read addresses
- sumIn  input  DATA_WIDTH  adder output (rdDataA + rdDataB), combinational from rdNumA/B
- wrData  output  DATA_WIDTH  register-file write data
- wrNum  output  REG_NUM_WIDTH  register-file write address
- wrEnable  output  1  register-file write strobe

## Operation
- State:
  - write-back register {wbValid, wbNum, wbData, wbOwner}
  - round-robin pointer lastGrant (0 or 1)
- Candidate selection, combinational, each cycle:
  - Only one requester valid: it is the candidate.
  - Both valid: the candidate is the requester ≠ lastGrant.
  - Neither valid: no candidate.
- Hazard: wbValid && (candidate SrcA == wbNum || candidate SrcB == wbNum).
- Issue condition: a candidate exists and there is no hazard.
- On issue:
  - Candidate's Ready = 1.
  - rdNumA/rdNumB = candidate SrcA/SrcB.
  - At the clock edge:
    - wbData ← sumIn
    - wbNum ← Dst
    - wbOwner ← candidate
    - wbValid ← 1
    - lastGrant ← candidate
- No issue (hazard or no candidate):
  - Both Ready = 0; rdNumA = rdNumB = 0.
  - wbValid ← 0 at the edge unless an issue occurs.
  - lastGrant is unchanged.
  - A stalled candidate keeps priority next cycle; the other requester is not granted in its place.
- Write-back, combinational from the wb register:
  - wrEnable = wbValid; wrNum = wbNum; wrData = wbData; result = wbData.
  - reqNDone = wbValid && wbOwner == N.
- Arithmetic: sum modulo 2^DATA_WIDTH, no carry out. srcA == srcB is legal (doubles the value).
- dst equal to srcA/srcB is legal; the read uses the old value.
- Back-to-back independent ops: one issue per cycle, write-back overlaps the next issue.
- Requesters must hold their fields stable while Valid && !Ready. The arbiter does not latch them before grant.
- Reset (rst = 0, asynchronous, at any time including mid-operation):
  - wbValid = 0, wbNum = 0, wbData = 0, lastGrant = 1 (requester 0 wins the first tie).
  - Any pending write is dropped; wrEnable drops immediately.
- Reset values of all outputs: Ready/Done/wrEnable = 0; rdNumA/B, wrNum = 0; wrData, result = 0.

## Timing
- Issue cycle T: Ready high, read addresses driven, sum sampled at the end of T.
- Cycle T+1: wrEnable high, write lands at the end of T+1, Done pulse in T+1. Latency from accept to Done is 1 cycle.
- Throughput: 1 op/cycle with no hazard. A RAW dependency on the immediately preceding op costs exactly 1 stall cycle.
- Ready is combinational from the Valid inputs and the wb register. Done and wrEnable are registered-state outputs.

## Test plan
- Reset then idle:
  - All outputs 0 while rst = 0.
  - After release with no Valid: wrEnable stays 0, Ready stays 0.
- Single op, R3=5, R4=7, req0 {3,4,dst 9}:
  - req0Ready at T.
  - At T+1: wrEnable = 1, wrNum = 9, wrData = 12, req0Done = 1. R9 = 12 afterwards.
- Both Valid continuously, independent regs: grants alternate 0,1,0,1 starting with 0. Done pulses follow one cycle later with matching owners.
- RAW stall:
  - Setup: R1 = 10, R2 = 20, R6 = 4.
  - req0 {1,2,dst 5} accepted at T.
  - req1 {5,6,dst 7} Valid at T+1: no Ready at T+1, Ready at T+2.
  - Result: R7 = 34, req1Done at T+3.
- Wrap-around: R0 = 0xFFFFFFFF, R1 = 2, op {0,1,dst 2} → wrData = 0x00000001.
- Reset mid-operation: assert rst in the cycle after an accept → wrEnable falls immediately, no Done, destination register unchanged.
